// File: rtl/huff_pkg.sv
// Shared types and default sizes for the Huffman table loader.
package huff_pkg;

  // Encoded (not one-hot) width of the loader state register
  localparam int STATE_W        = 3;

  // Default table geometry
  localparam int DATA_W_DEF     = 12;
  localparam int DC_ENTRIES_DEF = 8;
  localparam int AC_ENTRIES_DEF = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_CLR     = 3'd1,
    ST_LOAD_DC = 3'd2,
    ST_LOAD_AC = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_RUN     = 3'd5,
    ST_ERR     = 3'd6
  } huff_state_t;

endpackage

// File: rtl/huff_cfg_frame_chk.sv
// Word counter plus framing check for the table currently being loaded.
// adv_table fires on a correctly placed last word; frame_err fires on an
// early last or on a final-index word that lacks the last marker.
module huff_cfg_frame_chk #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              xfer,
  input  logic              last,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] cnt,
  output logic              adv_table,
  output logic              frame_err
);

  logic [ADDR_W-1:0] r_cnt;
  logic              w_at_end;

  assign w_at_end  = ({1'b0, r_cnt} == (len - (ADDR_W+1)'(1)));
  assign adv_table = xfer & last & w_at_end;
  assign frame_err = xfer & (last ^ w_at_end);
  assign cnt       = r_cnt;

  // Word index: cleared at sequence start and at each table boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr || adv_table) begin
      r_cnt <= '0;
    end else if (xfer) begin
      r_cnt <= r_cnt + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/huff_table_loader.sv
// Huffman decoder initialisation sequencer: streams the DC table then the
// AC table from the host into the lookup memories while holding the
// decoder in reset, then releases it into normal decode.
// Optional build macro HUFF_TBL_CKSUM_EN adds a 16-bit running checksum
// of written words that must match cksum_exp before release.
module huff_table_loader
  import huff_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DC_ENTRIES = DC_ENTRIES_DEF,
  parameter int AC_ENTRIES = AC_ENTRIES_DEF,
  parameter int SETTLE_CYC = 2,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_last,
  output logic              tbl_we,
  output logic [ADDR_W-1:0] tbl_addr,
  output logic [DATA_W-1:0] tbl_wdata,
  output logic              init_dc_ac,
  output logic              dec_reset,
  output logic              dec_reset_control,
  output logic              init_sr,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef HUFF_TBL_CKSUM_EN
  ,
  output logic [15:0]       cksum,
  input  logic [15:0]       cksum_exp
`endif
);

  localparam logic [ADDR_W:0] DC_LEN      = (ADDR_W+1)'(DC_ENTRIES);
  localparam logic [ADDR_W:0] AC_LEN      = (ADDR_W+1)'(AC_ENTRIES);
  localparam logic [2:0]      SETTLE_LOAD = 3'(SETTLE_CYC - 1);

  huff_state_t       r_state;
  huff_state_t       w_state_nxt;

  logic              r_cfg_ready;
  logic              r_tbl_we;
  logic [ADDR_W-1:0] r_tbl_addr;
  logic [DATA_W-1:0] r_tbl_wdata;
  logic              r_init_dc_ac;
  logic              r_dec_reset;
  logic              r_dec_reset_control;
  logic              r_init_sr;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [2:0]        r_settle_cnt;

  logic              w_xfer;
  logic [ADDR_W:0]   w_len;
  logic [ADDR_W-1:0] w_cnt;
  logic              w_adv;
  logic              w_frame_err;
  logic              w_clr_cnt;
  logic              w_dcac_nxt;
  logic              w_load_nxt;

  // Ready is high exactly while a LOAD state is active
  assign w_xfer    = cfg_valid & r_cfg_ready;
  assign w_len     = (r_state == ST_LOAD_DC) ? DC_LEN : AC_LEN;
  assign w_clr_cnt = (r_state == ST_CLR);

  huff_cfg_frame_chk #(
    .ADDR_W (ADDR_W)
  ) u_frame_chk (
    .clk       (clk),
    .reset     (reset),
    .clr       (w_clr_cnt),
    .xfer      (w_xfer),
    .last      (cfg_last),
    .len       (w_len),
    .cnt       (w_cnt),
    .adv_table (w_adv),
    .frame_err (w_frame_err)
  );

`ifdef HUFF_TBL_CKSUM_EN
  logic [15:0] r_cksum;
  logic [15:0] r_cksum_exp;
  logic [15:0] w_cksum_nxt;
  logic        w_cksum_bad;

  // Running sum including a write that is on the bus this cycle, so the
  // release decision sees the final word even with a one-cycle settle
  always_comb begin
    w_cksum_nxt = r_cksum;
    if (r_tbl_we) begin
      w_cksum_nxt = r_cksum + 16'(r_tbl_wdata);
    end else begin
      w_cksum_nxt = r_cksum;
    end
  end

  assign w_cksum_bad = (w_cksum_nxt != r_cksum_exp);
  assign cksum       = r_cksum;

  // Checksum accumulator and expected value captured on entry to SETTLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cksum     <= 16'd0;
      r_cksum_exp <= 16'd0;
    end else begin
      if (w_state_nxt == ST_CLR) begin
        r_cksum <= 16'd0;
      end else begin
        r_cksum <= w_cksum_nxt;
      end
      if ((r_state == ST_LOAD_AC) && (w_state_nxt == ST_SETTLE)) begin
        r_cksum_exp <= cksum_exp;
      end
    end
  end
`endif

  // Next-state decision
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_CLR;
        else       w_state_nxt = ST_IDLE;
      end
      ST_CLR: begin
        w_state_nxt = ST_LOAD_DC;
      end
      ST_LOAD_DC: begin
        if (w_frame_err) w_state_nxt = ST_ERR;
        else if (w_adv)  w_state_nxt = ST_LOAD_AC;
        else             w_state_nxt = ST_LOAD_DC;
      end
      ST_LOAD_AC: begin
        if (w_frame_err) w_state_nxt = ST_ERR;
        else if (w_adv)  w_state_nxt = ST_SETTLE;
        else             w_state_nxt = ST_LOAD_AC;
      end
      ST_SETTLE: begin
        if (r_settle_cnt == 3'd0) begin
`ifdef HUFF_TBL_CKSUM_EN
          if (w_cksum_bad) w_state_nxt = ST_ERR;
          else             w_state_nxt = ST_RUN;
`else
          w_state_nxt = ST_RUN;
`endif
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_RUN: begin
        if (start) w_state_nxt = ST_CLR;
        else       w_state_nxt = ST_RUN;
      end
      ST_ERR: begin
        if (start) w_state_nxt = ST_CLR;
        else       w_state_nxt = ST_ERR;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Table-select follows each write; between writes it tracks the table
  // about to be loaded, so the last DC word still lands in the DC table
  always_comb begin
    w_load_nxt = (w_state_nxt == ST_LOAD_DC) || (w_state_nxt == ST_LOAD_AC);
    w_dcac_nxt = r_init_dc_ac;
    if (w_xfer) begin
      w_dcac_nxt = (r_state == ST_LOAD_DC);
    end else if (w_state_nxt == ST_LOAD_AC) begin
      w_dcac_nxt = 1'b0;
    end else if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_CLR) ||
                 (w_state_nxt == ST_LOAD_DC)) begin
      w_dcac_nxt = 1'b1;
    end else begin
      w_dcac_nxt = r_init_dc_ac;
    end
  end

  // State register and registered control outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state             <= ST_IDLE;
      r_cfg_ready         <= 1'b0;
      r_tbl_we            <= 1'b0;
      r_tbl_addr          <= '0;
      r_tbl_wdata         <= '0;
      r_init_dc_ac        <= 1'b1;
      r_dec_reset         <= 1'b1;
      r_dec_reset_control <= 1'b1;
      r_init_sr           <= 1'b0;
      r_busy              <= 1'b0;
      r_done              <= 1'b0;
      r_err               <= 1'b0;
    end else begin
      r_state             <= w_state_nxt;
      r_cfg_ready         <= w_load_nxt;
      r_tbl_we            <= w_xfer;
      r_init_dc_ac        <= w_dcac_nxt;
      r_dec_reset         <= (w_state_nxt != ST_RUN);
      r_dec_reset_control <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_CLR) ||
                             (w_state_nxt == ST_ERR);
      r_init_sr           <= (w_state_nxt == ST_SETTLE);
      r_busy              <= (w_state_nxt == ST_CLR) || w_load_nxt ||
                             (w_state_nxt == ST_SETTLE);
      r_done              <= (r_state == ST_SETTLE) && (w_state_nxt == ST_RUN);
      if (w_state_nxt == ST_CLR) begin
        r_err <= 1'b0;
      end else if (w_state_nxt == ST_ERR) begin
        r_err <= 1'b1;
      end
      if (w_xfer) begin
        r_tbl_addr  <= w_cnt;
        r_tbl_wdata <= cfg_data;
      end
    end
  end

  // Settle down-counter: loaded on entry, counts to zero before release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_settle_cnt <= 3'd0;
    end else if ((r_state != ST_SETTLE) && (w_state_nxt == ST_SETTLE)) begin
      r_settle_cnt <= SETTLE_LOAD;
    end else if ((r_state == ST_SETTLE) && (r_settle_cnt != 3'd0)) begin
      r_settle_cnt <= r_settle_cnt - 3'd1;
    end
  end

  assign cfg_ready         = r_cfg_ready;
  assign tbl_we            = r_tbl_we;
  assign tbl_addr          = r_tbl_addr;
  assign tbl_wdata         = r_tbl_wdata;
  assign init_dc_ac        = r_init_dc_ac;
  assign dec_reset         = r_dec_reset;
  assign dec_reset_control = r_dec_reset_control;
  assign init_sr           = r_init_sr;
  assign busy              = r_busy;
  assign done              = r_done;
  assign err               = r_err;

endmodule

// File: tb/tb_huff_table_loader.sv
// Self-checking bench for huff_table_loader: random table words and
// handshake gaps, checked against a queue of expected table writes.
// Define HUFF_TBL_CKSUM_EN to also exercise the checksum option.
module tb_huff_table_loader;

  localparam int DATA_W     = 12;
  localparam int DC_N       = 8;
  localparam int AC_N       = 16;
  localparam int SETTLE_CYC = 2;
  localparam int ADDR_W     = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_last;
  logic              tbl_we;
  logic [ADDR_W-1:0] tbl_addr;
  logic [DATA_W-1:0] tbl_wdata;
  logic              init_dc_ac;
  logic              dec_reset;
  logic              dec_reset_control;
  logic              init_sr;
  logic              busy;
  logic              done;
  logic              err;
`ifdef HUFF_TBL_CKSUM_EN
  logic [15:0]       cksum;
  logic [15:0]       cksum_exp;
`endif

  huff_table_loader #(
    .DATA_W     (DATA_W),
    .DC_ENTRIES (DC_N),
    .AC_ENTRIES (AC_N),
    .SETTLE_CYC (SETTLE_CYC),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .cfg_data          (cfg_data),
    .cfg_last          (cfg_last),
    .tbl_we            (tbl_we),
    .tbl_addr          (tbl_addr),
    .tbl_wdata         (tbl_wdata),
    .init_dc_ac        (init_dc_ac),
    .dec_reset         (dec_reset),
    .dec_reset_control (dec_reset_control),
    .init_sr           (init_sr),
    .busy              (busy),
    .done              (done),
    .err               (err)
`ifdef HUFF_TBL_CKSUM_EN
    ,
    .cksum             (cksum),
    .cksum_exp         (cksum_exp)
`endif
  );

  typedef struct {
    bit dc;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_writes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Table-write scoreboard: every write must be the next accepted word
  always @(negedge clk) begin
    wr_t e;
    if (!reset && tbl_we) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(tbl_addr), 32'(e.addr));
        check("wr_data", 32'(tbl_wdata), 32'(e.data));
        check("wr_dcac", 32'(init_dc_ac), 32'(e.dc));
        check("wr_dec_reset", 32'(dec_reset), 32'd1);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Start a sequence and confirm the one-cycle clear state
  task automatic begin_load();
    pulse_start();
    @(negedge clk);
    check("clr_dec_reset", 32'(dec_reset), 32'd1);
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_err", 32'(err), 32'd0);
    check("clr_ready", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  // Offer count words (table indices base..base+count-1); cfg_last on
  // index last_idx. gap: 0 none, 1 every other cycle, 2 random.
  task automatic drive_table(input int base, input int count, input int last_idx,
                             input bit dc, input int gap, input int fixed_val);
    for (int i = 0; i < count; i++) begin
      int idle;
      int budget;
      bit xfer;
      logic [DATA_W-1:0] d;
      idle = (gap == 1) ? 1 : ((gap == 2) ? int'($urandom_range(0, 2)) : 0);
      repeat (idle) begin
        cfg_valid = 1'b0;
        @(posedge clk); #1;
      end
      d = (fixed_val >= 0) ? DATA_W'(fixed_val) : DATA_W'($urandom);
      cfg_valid = 1'b1;
      cfg_data  = d;
      cfg_last  = (base + i == last_idx);
      xfer   = 1'b0;
      budget = 0;
      while (!xfer && budget < 50) begin
        @(negedge clk);
        xfer = cfg_ready;
        @(posedge clk); #1;
        budget++;
      end
      if (!xfer) begin
        check("ready_timeout", 32'd0, 32'd1);
        break;
      end
      exp_q.push_back('{dc: dc, addr: base + i, data: int'(d)});
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // Wait for release, checking settle length and run-state outputs
  task automatic wait_done();
    int sr_cyc = 0;
    bit got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (init_sr) sr_cyc++;
    end
    check("done_seen", 32'(got), 32'd1);
    check("init_sr_cycles", 32'(sr_cyc), 32'(SETTLE_CYC));
    check("run_dec_reset", 32'(dec_reset), 32'd0);
    check("run_dec_rst_ctl", 32'(dec_reset_control), 32'd0);
    check("run_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic full_load(input int gap, input int fixed_val);
    int w0 = n_writes;
    begin_load();
    drive_table(0, DC_N, DC_N - 1, 1'b1, gap, fixed_val);
    drive_table(0, AC_N, AC_N - 1, 1'b0, gap, fixed_val);
    wait_done();
    check("load_writes", 32'(n_writes - w0), 32'(DC_N + AC_N));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Confirm ERR-state outputs after a framing failure
  task automatic check_err_state(input int w0, input int n_exp);
    @(negedge clk);
    check("err_flag", 32'(err), 32'd1);
    check("err_ready", 32'(cfg_ready), 32'd0);
    check("err_dec_reset", 32'(dec_reset), 32'd1);
    check("err_dec_rst_ctl", 32'(dec_reset_control), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    check("err_writes", 32'(n_writes - w0), 32'(n_exp));
    @(posedge clk); #1;
  endtask

  initial begin
    int w0;
    reset     = 1'b1;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    cfg_last  = 1'b0;
`ifdef HUFF_TBL_CKSUM_EN
    cksum_exp = 16'd0;
`endif
    #12;
    check("rst_ready", 32'(cfg_ready), 32'd0);
    check("rst_we", 32'(tbl_we), 32'd0);
    check("rst_addr", 32'(tbl_addr), 32'd0);
    check("rst_wdata", 32'(tbl_wdata), 32'd0);
    check("rst_dcac", 32'(init_dc_ac), 32'd1);
    check("rst_dec_reset", 32'(dec_reset), 32'd1);
    check("rst_dec_rst_ctl", 32'(dec_reset_control), 32'd1);
    check("rst_init_sr", 32'(init_sr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_dec_reset", 32'(dec_reset), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Back-to-back load, then reloads from RUN with gappy valid
    full_load(0, -1);
    full_load(1, -1);
    full_load(2, -1);

    // start while loading DC is ignored
    begin_load();
    drive_table(0, 3, DC_N - 1, 1'b1, 0, -1);
    pulse_start();
    check("ld_start_busy", 32'(busy), 32'd1);
    drive_table(3, DC_N - 3, DC_N - 1, 1'b1, 0, -1);
    drive_table(0, AC_N, AC_N - 1, 1'b0, 2, -1);
    wait_done();
    check("ld_start_q", 32'(exp_q.size()), 32'd0);

    // Early last on DC index 5
    w0 = n_writes;
    begin_load();
    drive_table(0, 6, 5, 1'b1, 0, -1);
    check_err_state(w0, 6);
    full_load(2, -1);

    // Final DC index without last
    w0 = n_writes;
    begin_load();
    drive_table(0, DC_N, -1, 1'b1, 2, -1);
    check_err_state(w0, DC_N);
    full_load(0, -1);

    // Early last on AC index 3
    w0 = n_writes;
    begin_load();
    drive_table(0, DC_N, DC_N - 1, 1'b1, 0, -1);
    drive_table(0, 4, 3, 1'b0, 0, -1);
    check_err_state(w0, DC_N + 4);
    full_load(0, -1);

    // Async reset while AC word 7 is offered
    begin_load();
    drive_table(0, DC_N, DC_N - 1, 1'b1, 0, -1);
    drive_table(0, 7, AC_N - 1, 1'b0, 0, -1);
    cfg_valid = 1'b1;
    cfg_data  = DATA_W'($urandom);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_we", 32'(tbl_we), 32'd0);
    check("mid_rst_dec_reset", 32'(dec_reset), 32'd1);
    check("mid_rst_dec_rst_ctl", 32'(dec_reset_control), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(cfg_ready), 32'd0);
    exp_q.delete();
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    full_load(2, -1);

`ifdef HUFF_TBL_CKSUM_EN
    // Matching checksum releases; a wrong one ends in ERR
    cksum_exp = 16'(DC_N + AC_N);
    full_load(0, 1);
    check("cksum_value", 32'(cksum), 32'(DC_N + AC_N));
    cksum_exp = 16'(DC_N + AC_N - 1);
    begin
      bit got_err = 1'b0;
      bit got_done = 1'b0;
      begin_load();
      drive_table(0, DC_N, DC_N - 1, 1'b1, 0, 1);
      drive_table(0, AC_N, AC_N - 1, 1'b0, 0, 1);
      for (int c = 0; c < 50 && !got_err; c++) begin
        @(negedge clk);
        if (done) got_done = 1'b1;
        if (err) got_err = 1'b1;
      end
      check("cksum_bad_err", 32'(got_err), 32'd1);
      check("cksum_bad_no_done", 32'(got_done), 32'd0);
      check("cksum_bad_dec_reset", 32'(dec_reset), 32'd1);
      check("cksum_bad_ready", 32'(cfg_ready), 32'd0);
      @(posedge clk); #1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
